// File: rtl/dac_slew_output.sv
// DAC output stage: offset add, saturate to DAC width, slew-rate limit, and
// an IDLE/TRACK/RAMP state machine that ramps the output back to zero on disable.
module dac_slew_output #(
    parameter int S_AXIS_DATA_WIDTH = 16,
    parameter int DAC_WIDTH         = 14   // must not exceed S_AXIS_DATA_WIDTH
) (
    input  logic                         a_clk,
    input  logic                         a_rst,
    input  logic [S_AXIS_DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                         S_AXIS_tvalid,
    input  logic [S_AXIS_DATA_WIDTH-1:0] offset,
    input  logic [DAC_WIDTH-1:0]         max_step,
    input  logic                         enable,
    input  logic                         hold,
    output logic [DAC_WIDTH-1:0]         M_AXIS_tdata,
    output logic                         M_AXIS_tvalid,
    output logic                         sat,
    output logic                         slewing,
    output logic [1:0]                   state
);
    localparam int SW = S_AXIS_DATA_WIDTH;
    localparam int DW = DAC_WIDTH;
    localparam int SH = SW - DW;

    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, RAMP = 2'd2} state_e;

    state_e          state_q, state_d;
    logic [SW:0]     sum_q, sum_d;
    logic [DW-1:0]   tgt_q, tgt_d;
    logic [DW-1:0]   cur_q, cur_d;
    logic [2:0]      vld_q, vld_d;     // [0] stage 1, [1] stage 2, [2] output pulse
    logic            sat_q, sat_d;
    logic            slew_q, slew_d;

    logic            clip_hi, clip_lo;
    logic [SW-1:0]   sat_val;
    logic            en_chg, hold_eff, eval, limit;
    logic [DW-1:0]   step_tgt, cur_next;
    logic [DW:0]     diff, mag, step_ext, cur_ext, stepped_ext;

    always_comb begin
        // Stage 1: full-precision sum, one extra bit so it never wraps
        sum_d = sum_q;
        if (S_AXIS_tvalid)
            sum_d = {S_AXIS_tdata[SW-1], S_AXIS_tdata} + {offset[SW-1], offset};

        // Stage 2: clamp to input range, then keep the top DW bits (floor)
        clip_hi = !sum_q[SW] &&  sum_q[SW-1];
        clip_lo =  sum_q[SW] && !sum_q[SW-1];
        sat_val = sum_q[SW-1:0];
        if (clip_hi) sat_val = {1'b0, {(SW-1){1'b1}}};
        if (clip_lo) sat_val = {1'b1, {(SW-1){1'b0}}};
        tgt_d = vld_q[0] ? DW'($signed(sat_val) >>> SH) : tgt_q;

        // A state change this cycle takes precedence; hold applies afterwards
        en_chg   = (state_q == IDLE  &&  enable) ||
                   (state_q == TRACK && !enable) ||
                   (state_q == RAMP  &&  enable);
        hold_eff = hold && !en_chg;

        // Stage 3: slew limiter; |diff| > max_step keeps the result strictly
        // between cur and target, so the step can never leave the DW range
        step_tgt    = (state_q == RAMP) ? '0 : tgt_q;
        cur_ext     = {cur_q[DW-1], cur_q};
        step_ext    = {1'b0, max_step};
        diff        = {step_tgt[DW-1], step_tgt} - cur_ext;
        mag         = diff[DW] ? (~diff + 1'b1) : diff;
        limit       = (max_step != '0) && (mag > step_ext);
        stepped_ext = {step_tgt[DW-1], step_tgt};
        if (limit)
            stepped_ext = diff[DW] ? (cur_ext - step_ext) : (cur_ext + step_ext);
        cur_next    = DW'(stepped_ext);

        eval = !hold_eff && ((state_q == TRACK && vld_q[1]) ||
                             (state_q == RAMP  && !enable));

        cur_d    = cur_q;
        slew_d   = 1'b0;
        vld_d[2] = 1'b0;
        if (eval) begin
            cur_d    = cur_next;
            slew_d   = limit;
            vld_d[2] = 1'b1;
        end

        // Samples arriving while idle are dropped before they reach stage 2
        vld_d[0] = S_AXIS_tvalid && (state_q != IDLE);
        vld_d[1] = vld_q[0] && (state_q != IDLE);

        sat_d = sat_q;
        if (vld_q[0] && (state_q != IDLE) && (clip_hi || clip_lo))
            sat_d = 1'b1;

        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                cur_d = '0;
                if (enable) begin
                    state_d = TRACK;
                    sat_d   = 1'b0;
                end
            end
            TRACK: if (!enable) state_d = RAMP;
            RAMP: begin
                if (enable)
                    state_d = TRACK;
                else if (eval && cur_next == '0)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            state_q <= IDLE;
            sum_q   <= '0;
            tgt_q   <= '0;
            cur_q   <= '0;
            vld_q   <= '0;
            sat_q   <= 1'b0;
            slew_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            vld_q   <= vld_d;
            sat_q   <= sat_d;
            slew_q  <= slew_d;
        end
    end

    assign M_AXIS_tdata  = cur_q;
    assign M_AXIS_tvalid = vld_q[2];
    assign sat           = sat_q;
    assign slewing       = slew_q;
    assign state         = state_q;
endmodule
